// File: rtl/vme_regbank_pkg.sv
// Shared types and helpers for the VME register bank: address classification and byte merging.
package vme_regbank_pkg;

    localparam int unsigned DataWDefault = 32;
    localparam int unsigned N_BE         = DataWDefault / 8;

    typedef enum logic [1:0] {
        AddrRw,
        AddrRo,
        AddrUnmapped
    } addr_class_e;

    function automatic addr_class_e addr_classify(input int unsigned addr,
                                                  input int unsigned n_rw,
                                                  input int unsigned n_ro);
        addr_class_e cls;
        if (addr < n_rw) begin
            cls = AddrRw;
        end else if (addr < n_rw + n_ro) begin
            cls = AddrRo;
        end else begin
            cls = AddrUnmapped;
        end
        return cls;
    endfunction

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/vme_regbank_if.sv
// Word-addressed VME memory strobe bus between the slave decoder and the register bank.
interface vme_regbank_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   VMEAddr;
    logic [DATA_W-1:0]   VMEWrData;
    logic [DATA_W/8-1:0] VMEWrBe;
    logic                VMERdMem;
    logic                VMEWrMem;
    logic [DATA_W-1:0]   VMERdData;
    logic                VMERdDone;
    logic                VMEWrDone;
    logic                VMEErr;

    modport master (
        output VMEAddr, VMEWrData, VMEWrBe, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone, VMEErr
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMEWrBe, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone, VMEErr
    );
endinterface

// File: rtl/vme_regbank_in_pipe.sv
// Optional input register stage in front of the decoder; PIPE_IN=0 is a straight wire.
module vme_regbank_in_pipe #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PIPE_IN = 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic                rd_i,
    input  logic                wr_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic                rd_o,
    output logic                wr_o
);
    if (PIPE_IN != 0) begin : g_pipe
        logic [ADDR_W-1:0]   addr_d, addr_q;
        logic [DATA_W-1:0]   wdata_d, wdata_q;
        logic [DATA_W/8-1:0] be_d, be_q;
        logic                rd_d, rd_q, wr_d, wr_q;

        always_comb begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
            be_d    = be_i;
            rd_d    = rd_i;
            wr_d    = wr_i;
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                addr_q  <= '0;
                wdata_q <= '0;
                be_q    <= '0;
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
            end else begin
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                be_q    <= be_d;
                rd_q    <= rd_d;
                wr_q    <= wr_d;
            end
        end

        assign addr_o  = addr_q;
        assign wdata_o = wdata_q;
        assign be_o    = be_q;
        assign rd_o    = rd_q;
        assign wr_o    = wr_q;
    end else begin : g_bypass
        assign addr_o  = addr_i;
        assign wdata_o = wdata_i;
        assign be_o    = be_i;
        assign rd_o    = rd_i;
        assign wr_o    = wr_i;
    end
endmodule

// File: rtl/vme_regbank.sv
// Parametrised VME register bank: N_RW control registers, N_RO status registers, one strobe bus.
module vme_regbank
    import vme_regbank_pkg::*;
#(
    parameter int unsigned           DATA_W  = DataWDefault,
    parameter int unsigned           ADDR_W  = 8,
    parameter int unsigned           N_RW    = 4,
    parameter int unsigned           N_RO    = 2,
    parameter logic [N_RW*DATA_W-1:0] RW_RST = '0,
    parameter int unsigned           PIPE_IN = 1
) (
    input  logic                                     Clk,
    input  logic                                     Rst_n,
    vme_regbank_if.slave                             bus,
    output logic [N_RW*DATA_W-1:0]                   rw_o,
    output logic [N_RW-1:0]                          wr_stb_o,
    input  logic [((N_RO > 0) ? N_RO : 1)*DATA_W-1:0] ro_i
);
    localparam int unsigned NumBe = DATA_W / 8;

    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [NumBe-1:0]  p_be;
    logic              p_rd, p_wr;

    vme_regbank_in_pipe #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PIPE_IN (PIPE_IN)
    ) u_in_pipe (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .addr_i  (bus.VMEAddr),
        .wdata_i (bus.VMEWrData),
        .be_i    (bus.VMEWrBe),
        .rd_i    (bus.VMERdMem),
        .wr_i    (bus.VMEWrMem),
        .addr_o  (p_addr),
        .wdata_o (p_wdata),
        .be_o    (p_be),
        .rd_o    (p_rd),
        .wr_o    (p_wr)
    );

    logic [N_RW*DATA_W-1:0] rw_d, rw_q;
    logic [N_RW-1:0]        wr_stb_d, wr_stb_q;
    logic [DATA_W-1:0]      rd_data_d, rd_data_q;
    logic                   rd_done_d, rd_done_q, wr_done_d, wr_done_q, err_d, err_q;
    logic                   pend_d, pend_q;
    logic [ADDR_W-1:0]      pend_addr_d, pend_addr_q;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_go;
    addr_class_e       wr_cls, rd_cls;

    always_comb begin
        rw_d        = rw_q;
        wr_stb_d    = '0;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        rd_data_d   = '0;
        err_d       = 1'b0;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        rd_go       = 1'b0;
        rd_addr     = p_addr;

        wr_cls = addr_classify(32'(p_addr), N_RW, N_RO);
        if (p_wr) begin
            wr_done_d = 1'b1;
            err_d     = (wr_cls == AddrUnmapped);
            for (int i = 0; i < N_RW; i++) begin
                if (wr_cls == AddrRw && p_addr == ADDR_W'(i)) begin
                    wr_stb_d[i] = 1'b1;
                    for (int b = 0; b < NumBe; b++) begin
                        rw_d[i*DATA_W + 8*b +: 8] = byte_merge(rw_q[i*DATA_W + 8*b +: 8],
                                                               p_wdata[8*b +: 8], p_be[b]);
                    end
                end
            end
        end

        // A deferred read owns the read port; a colliding read is parked behind the write.
        if (pend_q) begin
            rd_go   = 1'b1;
            rd_addr = pend_addr_q;
        end else if (p_rd && p_wr) begin
            pend_d      = 1'b1;
            pend_addr_d = p_addr;
        end else begin
            rd_go = p_rd;
        end

        rd_cls = addr_classify(32'(rd_addr), N_RW, N_RO);
        if (rd_go) begin
            rd_done_d = 1'b1;
            if (rd_cls == AddrUnmapped) begin
                err_d = 1'b1;
            end
            for (int i = 0; i < N_RW; i++) begin
                if (rd_addr == ADDR_W'(i)) begin
                    rd_data_d = rw_q[i*DATA_W +: DATA_W];
                end
            end
            for (int j = 0; j < N_RO; j++) begin
                if (rd_addr == ADDR_W'(N_RW + j)) begin
                    rd_data_d = ro_i[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rw_q        <= RW_RST;
            wr_stb_q    <= '0;
            rd_data_q   <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            rw_q        <= rw_d;
            wr_stb_q    <= wr_stb_d;
            rd_data_q   <= rd_data_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign bus.VMERdData = rd_data_q;
    assign bus.VMERdDone = rd_done_q;
    assign bus.VMEWrDone = wr_done_q;
    assign bus.VMEErr    = err_q;
    assign rw_o          = rw_q;
    assign wr_stb_o      = wr_stb_q;
endmodule

// File: tb/tb_vme_regbank.sv
// Directed bench for vme_regbank: one instance with PIPE_IN=0 and one with PIPE_IN=1 on shared stimulus.
module tb_vme_regbank;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned NRW = 4;
    localparam int unsigned NRO = 2;
    localparam logic [NRW*DW-1:0] RST_V = {96'h0, 32'hDEADBEEF};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vme_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    vme_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    logic [NRW*DW-1:0] rw0, rw1;
    logic [NRW-1:0]    stb0, stb1;
    logic [NRO*DW-1:0] ro;

    assign b1.VMEAddr   = b0.VMEAddr;
    assign b1.VMEWrData = b0.VMEWrData;
    assign b1.VMEWrBe   = b0.VMEWrBe;
    assign b1.VMERdMem  = b0.VMERdMem;
    assign b1.VMEWrMem  = b0.VMEWrMem;

    vme_regbank #(.DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .RW_RST(RST_V),
                  .PIPE_IN(0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .bus(b0), .rw_o(rw0), .wr_stb_o(stb0), .ro_i(ro)
    );
    vme_regbank #(.DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .RW_RST(RST_V),
                  .PIPE_IN(1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .bus(b1), .rw_o(rw1), .wr_stb_o(stb1), .ro_i(ro)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rw_of(input int d, input int i);
        return (d == 1) ? rw1[i*DW +: DW] : rw0[i*DW +: DW];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    logic [31:0] mdl [NRW];

    int          rd_at [2], wr_at [2], rd_n [2], wr_n [2], stb_n [2];
    logic [31:0] rd_dat [2];
    logic        rd_err [2], wr_err [2];
    logic [3:0]  stb_or [2];

    task automatic issue(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] dat, input logic [3:0] be);
        b0.VMEAddr   = a;
        b0.VMEWrData = dat;
        b0.VMEWrBe   = be;
        b0.VMERdMem  = rd;
        b0.VMEWrMem  = wr;
    endtask

    // Step ncyc cycles after an issue and log when each instance acknowledged.
    task automatic watch(input int ncyc);
        for (int d = 0; d < 2; d++) begin
            rd_at[d] = 0; wr_at[d] = 0; rd_n[d] = 0; wr_n[d] = 0; stb_n[d] = 0;
            rd_dat[d] = '0; rd_err[d] = 1'b0; wr_err[d] = 1'b0; stb_or[d] = '0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                b0.VMERdMem = 1'b0;
                b0.VMEWrMem = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                logic        rdd, wrd, er;
                logic [31:0] dat;
                logic [3:0]  st;
                rdd = (d == 1) ? b1.VMERdDone : b0.VMERdDone;
                wrd = (d == 1) ? b1.VMEWrDone : b0.VMEWrDone;
                er  = (d == 1) ? b1.VMEErr    : b0.VMEErr;
                dat = (d == 1) ? b1.VMERdData : b0.VMERdData;
                st  = (d == 1) ? stb1 : stb0;
                if (rdd) begin
                    rd_n[d]++;
                    if (rd_at[d] == 0) begin
                        rd_at[d] = c; rd_dat[d] = dat; rd_err[d] = er;
                    end
                end
                if (wrd) begin
                    wr_n[d]++;
                    if (wr_at[d] == 0) begin
                        wr_at[d] = c; wr_err[d] = er;
                    end
                end
                if (st != 0) begin
                    stb_n[d]++;
                    stb_or[d] = stb_or[d] | st;
                end
            end
        end
    endtask

    logic [32:0] exp_q [$];
    logic [32:0] got0 [$];
    logic [32:0] got1 [$];

    initial begin
        int          a;
        logic [31:0] dat;
        logic [3:0]  be;

        ro = {32'h0000BEEF, 32'hCAFE0001};
        issue(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        for (int i = 0; i < NRW; i++) mdl[i] = RST_V[i*DW +: DW];

        // Power-up reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NRW; i++) check_eq($sformatf("rst_rw%0d_d%0d", i, d), rw_of(d, i), mdl[i]);
        end
        check_eq("rst_rddata", {b1.VMERdData, b0.VMERdData}, 64'h0);
        check_eq("rst_flags", {b1.VMERdDone, b1.VMEWrDone, b1.VMEErr, b0.VMERdDone,
                               b0.VMEWrDone, b0.VMEErr}, 64'h0);
        check_eq("rst_stb", {stb1, stb0}, 64'h0);
        rst_n = 1'b1;

        // Reset asserted while a write is in flight
        @(posedge clk);
        #1;
        issue(1'b0, 1'b1, 8'h00, 32'h12345678, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        issue(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        #1;
        check_eq("midrst_rw0_d0", rw_of(0, 0), 32'hDEADBEEF);
        check_eq("midrst_rw0_d1", rw_of(1, 0), 32'hDEADBEEF);
        check_eq("midrst_wrdone", {b1.VMEWrDone, b0.VMEWrDone}, 64'h0);
        check_eq("midrst_rddata", {b1.VMERdData, b0.VMERdData}, 64'h0);
        check_eq("midrst_stb", {stb1, stb0}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(3);
        check_eq("midrst_noack_d1", wr_n[1], 0);
        check_eq("midrst_keep_d1", rw_of(1, 0), 32'hDEADBEEF);

        // Byte-enabled write
        issue(1'b0, 1'b1, 8'h01, 32'h11223344, 4'b0101);
        mdl[1] = 32'h00220044;
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("bew_lat_d%0d", d), wr_at[d], 1 + d);
            check_eq($sformatf("bew_cnt_d%0d", d), wr_n[d], 1);
            check_eq($sformatf("bew_err_d%0d", d), wr_err[d], 0);
            check_eq($sformatf("bew_stb_d%0d", d), stb_or[d], 4'b0010);
            check_eq($sformatf("bew_stbn_d%0d", d), stb_n[d], 1);
            check_eq($sformatf("bew_val_d%0d", d), rw_of(d, 1), 32'h00220044);
        end

        // RO reads
        issue(1'b1, 1'b0, 8'd4, 32'h0, 4'h0);
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("ro_lat_d%0d", d), rd_at[d], 1 + d);
            check_eq($sformatf("ro_cnt_d%0d", d), rd_n[d], 1);
            check_eq($sformatf("ro_dat_d%0d", d), rd_dat[d], 32'hCAFE0001);
            check_eq($sformatf("ro_err_d%0d", d), rd_err[d], 0);
        end
        issue(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
        watch(4);
        for (int d = 0; d < 2; d++) check_eq($sformatf("ro1_dat_d%0d", d), rd_dat[d], 32'h0000BEEF);

        // Unmapped read and write
        issue(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0);
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("um_rd_lat_d%0d", d), rd_at[d], 1 + d);
            check_eq($sformatf("um_rd_dat_d%0d", d), rd_dat[d], 32'h0);
            check_eq($sformatf("um_rd_err_d%0d", d), rd_err[d], 1);
        end
        issue(1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 4'hF);
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("um_wr_lat_d%0d", d), wr_at[d], 1 + d);
            check_eq($sformatf("um_wr_err_d%0d", d), wr_err[d], 1);
            check_eq($sformatf("um_wr_stb_d%0d", d), stb_n[d], 0);
            for (int i = 0; i < NRW; i++) check_eq($sformatf("um_wr_rw%0d_d%0d", i, d), rw_of(d, i), mdl[i]);
        end

        // Write to an RO address: acknowledged, no error, no strobe
        issue(1'b0, 1'b1, 8'd4, 32'hFFFFFFFF, 4'hF);
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("ro_wr_cnt_d%0d", d), wr_n[d], 1);
            check_eq($sformatf("ro_wr_err_d%0d", d), wr_err[d], 0);
            check_eq($sformatf("ro_wr_stb_d%0d", d), stb_n[d], 0);
        end

        // Simultaneous read and write to the same register
        issue(1'b1, 1'b1, 8'd2, 32'h5A5A5A5A, 4'hF);
        mdl[2] = 32'h5A5A5A5A;
        watch(5);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("sim_wr_lat_d%0d", d), wr_at[d], 1 + d);
            check_eq($sformatf("sim_rd_lat_d%0d", d), rd_at[d], 2 + d);
            check_eq($sformatf("sim_rd_cnt_d%0d", d), rd_n[d], 1);
            check_eq($sformatf("sim_rd_dat_d%0d", d), rd_dat[d], 32'h5A5A5A5A);
            check_eq($sformatf("sim_rd_err_d%0d", d), rd_err[d], 0);
        end

        // Back-to-back alternating writes and reads
        a = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                if (c % 2 == 0) begin
                    a   = (c / 2) % 4;
                    dat = 32'hA0000000 | (c << 16) | (c << 4) | 32'h3;
                    be  = (c % 4 == 0) ? 4'hF : 4'b0110;
                    issue(1'b0, 1'b1, 8'(a), dat, be);
                    mdl[a] = merge(mdl[a], dat, be);
                    exp_q.push_back({1'b0, 32'h0});
                end else begin
                    issue(1'b1, 1'b0, 8'(a), 32'h0, 4'h0);
                    exp_q.push_back({1'b1, mdl[a]});
                end
            end else begin
                issue(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            end
            @(posedge clk);
            #1;
            if (b0.VMEWrDone) got0.push_back({1'b0, 32'h0});
            if (b0.VMERdDone) got0.push_back({1'b1, b0.VMERdData});
            if (b1.VMEWrDone) got1.push_back({1'b0, 32'h0});
            if (b1.VMERdDone) got1.push_back({1'b1, b1.VMERdData});
        end
        check_eq("tput_cnt_d0", got0.size(), 16);
        check_eq("tput_cnt_d1", got1.size(), 16);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got0.size()) check_eq($sformatf("tput%0d_d0", k), got0[k], exp_q[k]);
            if (k < got1.size()) check_eq($sformatf("tput%0d_d1", k), got1[k], exp_q[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
